mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS datapath, the producer side of the HiLo register. It accepts one operation per Start pulse and computes the result over 32 iteration cycles. It then presents the 64-bit {Hi, Lo} result together with a one-cycle WriteEnable, in exactly the form the HiLo register's WriteData/WriteEnable inputs consume. The control unit stalls on Busy for mfhi/mflo and back-to-back mult/div.

---
 rtl/mult_div_if.sv | 31 +++
 rtl/mult_div_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// mult_div_if
// Request/result bundle between the MIPS control/datapath and the iterative
// multiply/divide unit.
//   Start, Op, A, B, HiLoIn : request side, driven by the master
//   Busy, Done, WriteEnable,
//   WriteData, DivByZero    : result side, driven by the unit (slave)
// WriteData/WriteEnable are shaped to feed the HiLo register directly.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic                 Start;
  logic [2:0]           Op;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   HiLoIn;
  logic                 Busy;
  logic                 Done;
  logic                 WriteEnable;
  logic [2*WIDTH-1:0]   WriteData;
  logic                 DivByZero;

  modport master (
    output Start, Op, A, B, HiLoIn,
    input  Busy, Done, WriteEnable, WriteData, DivByZero
  );

  modport slave (
    input  Start, Op, A, B, HiLoIn,
    output Busy, Done, WriteEnable, WriteData, DivByZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative WIDTH-bit multiply/divide unit producing the 64-bit {Hi, Lo}
// write for the HiLo register. One operation per Start pulse; each
// operation spends WIDTH iteration cycles plus one fix-up cycle in RUN, then
// one DONE cycle in which WriteEnable/Done/WriteData are presented.
// Ports:
//   Clock      : system clock, rising edge
//   Reset      : asynchronous, active-high; returns to IDLE, clears outputs
//   bus.slave  : Start/Op/A/B/HiLoIn in, Busy/Done/WriteEnable/WriteData/
//                DivByZero out
// Op: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//     100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU (Op[0]=1 -> unsigned)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       Clock,
  input  logic       Reset,
  mult_div_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Op[2:1] selects the operation group; Op[0] only selects signedness.
  localparam logic [1:0] GRP_MUL  = 2'b00;
  localparam logic [1:0] GRP_DIV  = 2'b01;
  localparam logic [1:0] GRP_MADD = 2'b10;
  localparam logic [1:0] GRP_MSUB = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Conditional two's-complement negation, operand width.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v,
                                             input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negation, result width.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v,
                                                input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // One radix-2 shift-add step. Multiplier sits in the low half and is
  // consumed from bit 0; partial product accumulates in the high half with
  // its carry shifted back in.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // One restoring division step. High half is the partial remainder, low
  // half shifts the dividend out of the top while quotient bits enter at
  // the bottom. The remainder stays below the divisor, so the shifted
  // partial fits in WIDTH+1 bits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem;
    logic             qb;
    part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = part - {1'b0, d};
    qb   = (part >= {1'b0, d});
    rem  = qb ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    return {rem, acc[WIDTH-2:0], qb};
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           grp_q, grp_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_a_q, neg_a_d;
  logic                 div_zero_q, div_zero_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   hilo_q, hilo_d;
  logic [2*WIDTH-1:0]   wdata_q, wdata_d;

  // Request decode, used only at acceptance.
  logic                 in_signed;
  logic                 in_div;
  logic                 in_neg_a;
  logic                 in_neg_b;
  logic [WIDTH-1:0]     in_mag_a;
  logic [WIDTH-1:0]     in_mag_b;

  assign in_signed = ~bus.Op[0];
  assign in_div    = (bus.Op[2:1] == GRP_DIV);
  assign in_neg_a  = in_signed & bus.A[WIDTH-1];
  assign in_neg_b  = in_signed & bus.B[WIDTH-1];
  assign in_mag_a  = neg_w(bus.A, in_neg_a);
  assign in_mag_b  = neg_w(bus.B, in_neg_b);

  // Sign fix-up and result mapping, registered on the RUN -> DONE edge.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [2*WIDTH-1:0]   div_res;
  logic [2*WIDTH-1:0]   result;

  assign prod_fix = neg_2w(acc_q, neg_res_q);

  // Divide by zero reports {A, all-ones}; A is rebuilt from its magnitude.
  assign div_res = div_zero_q
                 ? {neg_w(mag_a_q, neg_a_q), {WIDTH{1'b1}}}
                 : {neg_w(acc_q[2*WIDTH-1:WIDTH], neg_a_q),
                    neg_w(acc_q[WIDTH-1:0], neg_res_q)};

  always_comb begin
    result = prod_fix;
    case (grp_q)
      GRP_MUL:  result = prod_fix;
      GRP_DIV:  result = div_res;
      GRP_MADD: result = hilo_q + prod_fix;
      GRP_MSUB: result = hilo_q - prod_fix;
      default:  result = prod_fix;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grp_d      = grp_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    neg_res_d  = neg_res_q;
    neg_a_d    = neg_a_q;
    div_zero_d = div_zero_q;
    acc_d      = acc_q;
    hilo_d     = hilo_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          grp_d      = bus.Op[2:1];
          mag_a_d    = in_mag_a;
          mag_b_d    = in_mag_b;
          neg_res_d  = in_neg_a ^ in_neg_b;
          neg_a_d    = in_neg_a;
          div_zero_d = in_div && (bus.B == '0);
          hilo_d     = bus.HiLoIn;
          // Divide shifts the dividend out; multiply consumes the multiplier.
          acc_d      = in_div ? {{WIDTH{1'b0}}, in_mag_a}
                              : {{WIDTH{1'b0}}, in_mag_b};
        end
      end

      S_RUN: begin
        // WIDTH iterations, then one more RUN cycle commits the fixed-up result.
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = S_DONE;
          wdata_d = result;
        end else begin
          acc_d = (grp_q == GRP_DIV) ? div_step(acc_q, mag_b_q)
                                     : mul_step(acc_q, mag_a_q);
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      grp_q      <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      neg_res_q  <= 1'b0;
      neg_a_q    <= 1'b0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      hilo_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grp_q      <= grp_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      neg_res_q  <= neg_res_d;
      neg_a_q    <= neg_a_d;
      div_zero_q <= div_zero_d;
      acc_q      <= acc_d;
      hilo_q     <= hilo_d;
      wdata_q    <= wdata_d;
    end
  end

  // Status outputs are decodes of the state register, so they are glitch-free
  // for the whole DONE cycle and drop immediately on Reset.
  assign bus.Busy        = (state_q != S_IDLE);
  assign bus.Done        = (state_q == S_DONE);
  assign bus.WriteEnable = (state_q == S_DONE);
  assign bus.DivByZero   = (state_q == S_DONE) & div_zero_q;
  assign bus.WriteData   = wdata_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MADD  = 3'd4;
  localparam logic [2:0] MADDU = 3'd5;
  localparam logic [2:0] MSUB  = 3'd6;
  localparam logic [2:0] MSUBU = 3'd7;
  localparam int         LAT   = 33;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    logic [63:0] exp;
    logic        exp_dz;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        dz;
    int          acc;
  } sb_t;

  sb_t         sbq[$];
  vec_t        vt[15];
  logic        prev_we = 1'b0;
  logic [63:0] last_exp = '0;

  // Reference model built on native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] prod;
    if (op[0]) begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end
    prod = sa * sb;
    case (op[2:1])
      2'b00: return prod;
      2'b01: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      2'b10: return hilo + prod;
      default: return hilo - prod;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard consumer: every write must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    checks++;
    if ((bus.Done !== bus.WriteEnable) || (bus.DivByZero === 1'b1 && bus.WriteEnable !== 1'b1)) begin
      errors++;
      $display("FAIL pulse_align done=%b we=%b dz=%b", bus.Done, bus.WriteEnable, bus.DivByZero);
    end
    if (prev_we) begin
      check("busy_after_done", {63'b0, bus.Busy}, 64'd0);
      check("wdata_hold", bus.WriteData, last_exp);
    end
    if (bus.WriteEnable === 1'b1) begin
      sb_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write data=%h exp=none", bus.WriteData);
      end else begin
        e = sbq.pop_front();
        last_exp = e.data;
        check("wdata", bus.WriteData, e.data);
        check("divbyzero", {63'b0, bus.DivByZero}, {63'b0, e.dz});
        check("latency", 64'(cyc - e.acc), 64'(LAT));
      end
    end
    prev_we = (bus.WriteEnable === 1'b1);
  end

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hilo, input logic push,
                          input logic [63:0] exp, input logic exp_dz);
    sb_t e;
    @(negedge clk);
    bus.Op     = op;
    bus.A      = a;
    bus.B      = b;
    bus.HiLoIn = hilo;
    bus.Start  = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    check("busy_on_accept", {63'b0, bus.Busy}, 64'd1);
    if (push) begin
      e.data = exp;
      e.dz   = exp_dz;
      e.acc  = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.Busy !== 1'b0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL idle_timeout busy=%b after=%0d", bus.Busy, n);
    end
    // One extra cycle so the post-DONE checks run before the next request.
    @(posedge clk);
    #1;
    check("sb_drained", 64'(sbq.size()), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    start_op(v.op, v.a, v.b, v.hilo, 1'b1, v.exp, v.exp_dz);
    wait_idle();
  endtask

  initial begin
    vec_t v;
    int   n;

    vt[0]  = '{MULT,  32'hFFFFFFFD, 32'd5,        64'h0,                  64'hFFFFFFFF_FFFFFFF1, 1'b0};
    vt[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                  64'hFFFFFFFE_00000001, 1'b0};
    vt[2]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                  64'h00000000_00000001, 1'b0};
    vt[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,        64'h0,                  64'hFFFFFFFF_FFFFFFFD, 1'b0};
    vt[4]  = '{DIVU,  32'd7,        32'd2,        64'h0,                  64'h00000001_00000003, 1'b0};
    vt[5]  = '{DIVU,  32'h12345678, 32'd0,        64'h0,                  64'h12345678_FFFFFFFF, 1'b1};
    vt[6]  = '{MADDU, 32'd1,        32'd1,        64'hFFFFFFFF_FFFFFFFF,  64'h00000000_00000000, 1'b0};
    vt[7]  = '{MSUB,  32'd2,        32'd3,        64'h0,                  64'hFFFFFFFF_FFFFFFFA, 1'b0};
    vt[8]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 64'h0,                  64'h00000000_80000000, 1'b0};
    vt[9]  = '{DIV,   32'hFFFFFFF9, 32'd0,        64'h0,                  64'hFFFFFFF9_FFFFFFFF, 1'b1};
    vt[10] = '{MULT,  32'h80000000, 32'h80000000, 64'h0,                  64'h40000000_00000000, 1'b0};
    vt[11] = '{DIV,   32'd7,        32'hFFFFFFFE, 64'h0,                  64'h00000001_FFFFFFFD, 1'b0};
    vt[12] = '{MADD,  32'hFFFFFFFD, 32'd5,        64'h00000000_00000010,  64'h00000000_00000001, 1'b0};
    vt[13] = '{MSUBU, 32'hFFFFFFFF, 32'd2,        64'h00000001_00000000,  64'hFFFFFFFF_00000002, 1'b0};
    vt[14] = '{DIVU,  32'hFFFFFFFF, 32'h10,       64'h0,                  64'h0000000F_0FFFFFFF, 1'b0};

    bus.Start  = 1'b0;
    bus.Op     = '0;
    bus.A      = '0;
    bus.B      = '0;
    bus.HiLoIn = '0;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {63'b0, bus.Busy},        64'd0);
    check("rst_we",    {63'b0, bus.WriteEnable}, 64'd0);
    check("rst_done",  {63'b0, bus.Done},        64'd0);
    check("rst_dz",    {63'b0, bus.DivByZero},   64'd0);
    check("rst_wdata", bus.WriteData,            64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    for (int i = 0; i < 10; i++) begin
      v.op   = 3'($urandom_range(0, 7));
      v.a    = $urandom;
      v.b    = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      v.hilo = {$urandom, $urandom};
      v.exp  = model(v.op, v.a, v.b, v.hilo);
      v.exp_dz = (v.op[2:1] == 2'b01) && (v.b == 32'd0);
      run_vec(v);
    end

    // New request mid-RUN and during DONE must be ignored.
    start_op(MULT, 32'd3, 32'd4, 64'h0, 1'b1, 64'd12, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.Op = MULTU; bus.A = 32'd7; bus.B = 32'd7; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    n = 0;
    while (bus.WriteEnable !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("we_seen", {63'b0, bus.WriteEnable}, 64'd1);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_idle();
    repeat (40) @(posedge clk);
    #1;
    check("no_queued_start", {63'b0, bus.Busy}, 64'd0);

    // Reset in the middle of RUN discards the operation.
    start_op(MULTU, 32'h0000DEAD, 32'h0000BEEF, 64'h0, 1'b0, 64'h0, 1'b0);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    bus.Start = 1'b1;
    bus.Op = MULT; bus.A = 32'd9; bus.B = 32'd9;
    #1;
    check("mid_rst_busy",  {63'b0, bus.Busy},        64'd0);
    check("mid_rst_we",    {63'b0, bus.WriteEnable}, 64'd0);
    check("mid_rst_done",  {63'b0, bus.Done},        64'd0);
    check("mid_rst_dz",    {63'b0, bus.DivByZero},   64'd0);
    check("mid_rst_wdata", bus.WriteData,            64'd0);
    repeat (2) @(negedge clk);
    bus.Start = 1'b0;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_idle", {63'b0, bus.Busy}, 64'd0);
    check("post_rst_wdata", bus.WriteData, 64'd0);

    // Normal operation resumes after reset.
    v = '{DIVU, 32'd100, 32'd7, 64'h0, 64'h00000002_0000000E, 1'b0};
    run_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
